obstacle_spawner: RTL and testbench
===================================

Name: obstacle_spawner

Overview:
- Sits directly upstream of the per-slot `obstacle` instances and decides when and what to spawn.
- Tracks which of SLOT_COUNT slots are busy and checks the gap of the most recently spawned obstacle.
- Picks a type using the random source, with a duplicate-limit rule and a speed gate, then pulses `start` to a free slot on a frame `update` tick.
- Holds `typ` of each slot stable for the slot's lifetime.

Parameters:
- SLOT_COUNT, 3, number of obstacle slots driven.
- MAX_DUP, 2, maximum consecutive spawns of the same type.
- MAX_REROLL, 8, rejected picks allowed before the fallback to CACTUS_SMALL.
- GAME_WIDTH, 640, spawn-check right edge in pixels.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; game running, spawning enabled
- update  in  1  one-cycle frame tick, shared with the obstacles
- crash  in  1  one-cycle crash pulse
- speed  in  15  current speed, scaled by 1024
- random  in  16  LFSR output; changes every cycle
- remove  in  SLOT_COUNT  per-slot remove level from the obstacles
- x_pos  in  SLOT_COUNT x 11 (signed)  per-slot x position
- width  in  SLOT_COUNT x 10  per-slot width
- gap  in  SLOT_COUNT x 11  per-slot gap
- start  out  SLOT_COUNT  per-slot spawn pulse
- typ  out  SLOT_COUNT x obstacle_pkg::type_t  per-slot obstacle type
- busy  out  SLOT_COUNT  slot occupied
- crashed  out  1  spawner frozen

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; start=0; typ=NONE; busy=0; crashed=0; last=0; reroll count=0; type history = {NONE, NONE}.
- Busy tracking: busy[i] sets on the cycle start[i] is issued. It clears on the clock where remove[i]=1 and start[i]=0.
- States and transitions:
  - IDLE: when run=1 and update=1, go to SCAN.
  - WAIT_TICK: on update=1, go to SCAN. If run=0, go to IDLE.
  - SCAN (1 cycle):
    - If no slot is busy, go to PICK.
    - Otherwise, if some slot is free and x_pos[last] + width[last] + gap[last] < GAME_WIDTH, go to PICK.
    - Otherwise go to WAIT_TICK.
    - The sum is evaluated as 13-bit signed, so negative x_pos must work.
  - PICK (1 cycle per try): candidate = random[1:0].
    - Reject if the candidate is 0 (NONE).
    - Reject if the candidate is PTERODACTYL and speed < 8704.
    - Reject if the candidate equals both history entries (MAX_DUP=2).
    - On reject: increment the reroll count and stay in PICK.
    - When the count reaches MAX_REROLL: candidate = CACTUS_SMALL, rules not applied.
    - On accept: latch the candidate and the lowest-index free slot, then go to ARMED.
  - ARMED: on update=1, the following happen in the same cycle:
    - start[slot]=1 for exactly that cycle and typ[slot] = candidate.
    - busy[slot] sets, last = slot, history shifts in the candidate, reroll count clears.
    - Next state is WAIT_TICK, so no rescan happens until the following tick, while the new obstacle initialises.
  - CRASHED: terminal. Leave only via reset.
- typ[i] changes only on the cycle start[i] is issued; it is otherwise held, including after remove.
- At most one start bit is high in any cycle, and start is never asserted without update.
- crash=1 in any state goes to CRASHED with start=0 and crashed=1. crash wins over a simultaneous update in ARMED.
- Free slot in ARMED turns busy: impossible, since the latched slot has busy=0 and only this block sets busy.
- run drops mid-PICK or in ARMED: return to IDLE. The latched candidate is discarded and no start is issued.

Optional Feature:
- Macro SPAWN_PTERO_EN.
- Defined: PTERODACTYL is a legal candidate, subject to the speed gate.
- Undefined: candidate 3 is always rejected, so only cacti spawn.

Test Plan:
- Reset, then run=1 with an update: SCAN finds no slots busy, PICK gets random[1:0]=1, and on the next update start=001 with typ[0]=CACTUS_SMALL.
- Slot 0 busy with x_pos=300, width=17, gap=200 (sum 517 < 640): on the next update, start[1]=1. Same case with gap=400 (sum 717): no start.
- speed=5000 (below 8704) and random[1:0]=3 for 8 cycles: the fallback gives typ=CACTUS_SMALL.
- History {LARGE, LARGE} and random[1:0]=2, then 1: LARGE is rejected and SMALL is issued.
- crash pulse on the same cycle as update in ARMED: no start, crashed=1, and it stays frozen until rst=0.
- remove[0]=1 while busy[0]=1 and slot 0 is last: busy clears, and the next update leads to a spawn into slot 0 with no gap check.

Source files
------------

// File: rtl/obstacle_spawner_if.sv
// rtl/obstacle_spawner_if.sv - obstacle type package and spawner-to-slot bus interface

package obstacle_pkg;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        CACTUS_SMALL = 2'd1,
        CACTUS_LARGE = 2'd2,
        PTERODACTYL  = 2'd3
    } type_t;

endpackage

interface obstacle_spawner_if #(
    parameter int SLOT_COUNT = 3
);
    import obstacle_pkg::*;

    // Spawner-driven per-slot controls
    logic [SLOT_COUNT-1:0] start;
    type_t                 typ [SLOT_COUNT];
    logic [SLOT_COUNT-1:0] busy;

    // Obstacle-driven per-slot status
    logic [SLOT_COUNT-1:0] remove;
    logic signed [10:0]    x_pos [SLOT_COUNT];
    logic [9:0]            width [SLOT_COUNT];
    logic [10:0]           gap   [SLOT_COUNT];

    modport master (
        output start, typ, busy,
        input  remove, x_pos, width, gap
    );

    modport slave (
        input  start, typ, busy,
        output remove, x_pos, width, gap
    );

endinterface

// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - decides when and what obstacle to spawn into free slots; SPAWN_PTERO_EN enables pterodactyls

module obstacle_spawner
    import obstacle_pkg::*;
#(
    parameter int SLOT_COUNT = 3,
    parameter int MAX_DUP    = 2,
    parameter int MAX_REROLL = 8,
    parameter int GAME_WIDTH = 640
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                update,
    input  logic                crash,
    input  logic [14:0]         speed,
    input  logic [15:0]         random,
    obstacle_spawner_if.master  slots,
    output logic                crashed
);

    localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
    localparam int CW = $clog2(MAX_REROLL + 1);
    localparam logic [14:0] PTERO_MIN_SPEED = 15'd8704;
    localparam logic signed [12:0] RIGHT_EDGE = 13'(GAME_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SCAN,
        PICK,
        ARMED,
        CRASHED
    } state_t;

    state_t                state;
    logic [SLOT_COUNT-1:0] start_q;
    logic [SLOT_COUNT-1:0] busy_q;
    type_t                 typ_q [SLOT_COUNT];
    logic [SW-1:0]         last;
    logic [SW-1:0]         slot_sel;
    type_t                 cand;
    type_t                 hist [MAX_DUP];
    logic [CW-1:0]         reroll_cnt;

    logic [SW-1:0]         free_idx;
    logic                  any_free;
    logic signed [10:0]    last_x;
    logic [9:0]            last_w;
    logic [10:0]           last_g;
    logic signed [12:0]    reach;
    logic                  gap_ok;
    type_t                 pick;
    logic                  dup_all;
    logic                  ptero_bad;
    logic                  reject;
    logic                  fallback;

    assign slots.start = start_q;
    assign slots.busy  = busy_q;
    assign slots.typ   = typ_q;

    // Lowest-index free slot; scanning downwards leaves the smallest index last
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = SW'(i);
                any_free = 1'b1;
            end
        end
    end

    // Right edge of the newest obstacle plus its gap, signed so off-screen x works
    always_comb begin
        last_x = slots.x_pos[last];
        last_w = slots.width[last];
        last_g = slots.gap[last];
        reach  = $signed({{2{last_x[10]}}, last_x})
               + $signed({3'b000, last_w})
               + $signed({2'b00, last_g});
        gap_ok = (reach < RIGHT_EDGE);
    end

    // Candidate acceptance rules for the current random draw
    always_comb begin
        pick    = type_t'(random[1:0]);
        dup_all = 1'b1;
        for (int i = 0; i < MAX_DUP; i++) begin
            if (hist[i] != pick) begin
                dup_all = 1'b0;
            end
        end
`ifdef SPAWN_PTERO_EN
        ptero_bad = (pick == PTERODACTYL) && (speed < PTERO_MIN_SPEED);
`else
        ptero_bad = (pick == PTERODACTYL);
`endif
        reject   = (pick == NONE) || dup_all || ptero_bad;
        fallback = (reroll_cnt >= CW'(MAX_REROLL));
    end

    // Spawn FSM with registered start/typ/busy/crashed outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            start_q    <= '0;
            busy_q     <= '0;
            crashed    <= 1'b0;
            last       <= '0;
            slot_sel   <= '0;
            cand       <= NONE;
            reroll_cnt <= '0;
            for (int i = 0; i < SLOT_COUNT; i++) begin
                typ_q[i] <= NONE;
            end
            for (int i = 0; i < MAX_DUP; i++) begin
                hist[i] <= NONE;
            end
        end else begin
            start_q <= '0;

            // Slot release; a same-cycle spawn into the slot below takes precedence
            for (int i = 0; i < SLOT_COUNT; i++) begin
                if (slots.remove[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end

            if (crash) begin
                state   <= CRASHED;
                crashed <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (run && update) begin
                            state <= SCAN;
                        end
                    end

                    WAIT_TICK: begin
                        if (!run) begin
                            state <= IDLE;
                        end else if (update) begin
                            state <= SCAN;
                        end
                    end

                    SCAN: begin
                        if (!run) begin
                            state <= IDLE;
                        end else if ((busy_q == '0) || (any_free && gap_ok)) begin
                            state <= PICK;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end

                    PICK: begin
                        if (!run) begin
                            state      <= IDLE;
                            reroll_cnt <= '0;
                        end else if (fallback) begin
                            cand     <= CACTUS_SMALL;
                            slot_sel <= free_idx;
                            state    <= ARMED;
                        end else if (reject) begin
                            reroll_cnt <= reroll_cnt + CW'(1);
                        end else begin
                            cand     <= pick;
                            slot_sel <= free_idx;
                            state    <= ARMED;
                        end
                    end

                    ARMED: begin
                        if (!run) begin
                            state      <= IDLE;
                            reroll_cnt <= '0;
                        end else if (update) begin
                            start_q[slot_sel] <= 1'b1;
                            typ_q[slot_sel]   <= cand;
                            busy_q[slot_sel]  <= 1'b1;
                            last              <= slot_sel;
                            hist[0]           <= cand;
                            for (int i = 1; i < MAX_DUP; i++) begin
                                hist[i] <= hist[i-1];
                            end
                            reroll_cnt <= '0;
                            state      <= WAIT_TICK;
                        end
                    end

                    CRASHED: begin
                        state <= CRASHED;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb/tb_obstacle_spawner.sv - scoreboard bench for obstacle_spawner

module tb_obstacle_spawner;
    import obstacle_pkg::*;

    typedef struct {
        int    slot;
        type_t typ;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        update;
    logic        crash;
    logic [14:0] speed;
    logic [15:0] random;
    logic        crashed;

    int   tests;
    int   fails;
    exp_t q[$];
    logic upd_q;

    obstacle_spawner_if #(.SLOT_COUNT(3)) slots ();

    obstacle_spawner #(
        .SLOT_COUNT (3),
        .MAX_DUP    (2),
        .MAX_REROLL (8),
        .GAME_WIDTH (640)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .update  (update),
        .crash   (crash),
        .speed   (speed),
        .random  (random),
        .slots   (slots),
        .crashed (crashed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what the DUT saw on update at each active edge
    always @(posedge clk) upd_q = update;

    // Monitor: every start pulse is checked against the scoreboard head
    always @(negedge clk) begin
        if (rst && slots.start != 3'b000) begin
            exp_t e;
            tests++;
            if (!upd_q || $countones(slots.start) != 1) begin
                fails++;
                $display("FAIL start_shape start=%b update=%b", slots.start, upd_q);
            end
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_start start=%b typ0=%0d typ1=%0d typ2=%0d",
                         slots.start, slots.typ[0], slots.typ[1], slots.typ[2]);
            end else begin
                e = q.pop_front();
                if (slots.start != (3'b001 << e.slot) || slots.typ[e.slot] != e.typ
                    || !slots.busy[e.slot]) begin
                    fails++;
                    $display("FAIL spawn start=%b typ=%0d busy=%b expected slot=%0d typ=%0d",
                             slots.start, slots.typ[e.slot], slots.busy, e.slot, e.typ);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        update = 1'b1;
        cyc(1);
        update = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        run    = 1'b0;
        update = 1'b0;
        crash  = 1'b0;
        speed  = 15'd10000;
        random = 16'h0001;
        slots.remove = 3'b000;
        for (int i = 0; i < 3; i++) begin
            slots.x_pos[i] = 11'sd0;
            slots.width[i] = 10'd0;
            slots.gap[i]   = 11'd0;
        end
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic expect_spawn(input int slot, input type_t t);
        exp_t e;
        e.slot = slot;
        e.typ  = t;
        q.push_back(e);
    endtask

    task automatic drained(input string name);
        @(negedge clk);
        check(name, q.size(), 0);
        q.delete();
        #1;
    endtask

    task automatic pulse_remove(input logic [2:0] m);
        slots.remove = m;
        cyc(1);
        slots.remove = 3'b000;
    endtask

    // Spawn from WAIT_TICK or IDLE: tick to scan, settle into ARMED, tick to fire
    task automatic spawn(input int slot, input type_t t, input int settle);
        tick();
        cyc(settle);
        expect_spawn(slot, t);
        tick();
        cyc(1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        do_reset();

        @(negedge clk);
        check("reset_start", int'(slots.start), 0);
        check("reset_busy", int'(slots.busy), 0);
        check("reset_crashed", int'(crashed), 0);
        check("reset_typ0", int'(slots.typ[0]), int'(NONE));
        check("reset_typ2", int'(slots.typ[2]), int'(NONE));
        #1;

        // First spawn from empty field
        run    = 1'b1;
        random = 16'h0001;
        spawn(0, CACTUS_SMALL, 3);
        drained("first_spawn");

        // Gap check passes: 300 + 17 + 200 = 517
        slots.x_pos[0] = 11'sd300;
        slots.width[0] = 10'd17;
        slots.gap[0]   = 11'd200;
        spawn(1, CACTUS_SMALL, 3);
        drained("gap_517");

        // Gap check blocks: 300 + 17 + 400 = 717
        random         = 16'h0002;
        slots.x_pos[1] = 11'sd300;
        slots.width[1] = 10'd17;
        slots.gap[1]   = 11'd400;
        tick(); cyc(3); tick(); cyc(3);
        drained("gap_717");
        check("gap_717_busy", int'(slots.busy), 3);

        // Negative x_pos: -100 + 17 + 400 = 317 passes
        slots.x_pos[1] = -11'sd100;
        spawn(2, CACTUS_LARGE, 3);
        drained("negative_x");
        check("all_busy", int'(slots.busy), 7);

        // Remove of the last slot frees the field; no gap check applies
        do_reset();
        run = 1'b1;
        spawn(0, CACTUS_SMALL, 3);
        slots.x_pos[0] = 11'sd600;
        slots.width[0] = 10'd17;
        slots.gap[0]   = 11'd200;
        pulse_remove(3'b001);
        @(negedge clk);
        check("remove_busy", int'(slots.busy), 0);
        check("typ_held_after_remove", int'(slots.typ[0]), int'(CACTUS_SMALL));
        #1;
        random = 16'h0002;
        spawn(0, CACTUS_LARGE, 3);
        drained("respawn_slot0");

        // Duplicate limit: LARGE, LARGE then LARGE is rejected until SMALL shows up
        do_reset();
        run    = 1'b1;
        random = 16'h0002;
        spawn(0, CACTUS_LARGE, 3);
        pulse_remove(3'b001);
        spawn(0, CACTUS_LARGE, 3);
        pulse_remove(3'b001);
        tick();
        cyc(4);
        random = 16'h0001;
        cyc(2);
        expect_spawn(0, CACTUS_SMALL);
        tick();
        cyc(1);
        drained("dup_limit");

        // Slow speed with pterodactyl draws falls back after the reroll budget
        do_reset();
        run    = 1'b1;
        speed  = 15'd5000;
        random = 16'h0003;
        spawn(0, CACTUS_SMALL, 12);
        drained("fallback_slow");

        // Fast speed: pterodactyl only when the feature is built in
        pulse_remove(3'b001);
        speed = 15'd10000;
`ifdef SPAWN_PTERO_EN
        spawn(0, PTERODACTYL, 12);
`else
        spawn(0, CACTUS_SMALL, 12);
`endif
        drained("ptero_fast");

        // Crash together with update in ARMED: no start, frozen until reset
        do_reset();
        run    = 1'b1;
        random = 16'h0001;
        tick();
        cyc(3);
        update = 1'b1;
        crash  = 1'b1;
        cyc(1);
        update = 1'b0;
        crash  = 1'b0;
        @(negedge clk);
        check("crash_flag", int'(crashed), 1);
        check("crash_busy", int'(slots.busy), 0);
        #1;
        tick(); cyc(3); tick(); cyc(3);
        drained("crash_frozen");
        check("crash_held", int'(crashed), 1);
        do_reset();
        @(negedge clk);
        check("crash_cleared", int'(crashed), 0);
        #1;

        // run drops in ARMED: candidate discarded, restart needs a fresh scan
        run    = 1'b1;
        random = 16'h0001;
        tick();
        cyc(3);
        run = 1'b0;
        cyc(2);
        run = 1'b1;
        tick();
        cyc(3);
        expect_spawn(0, CACTUS_SMALL);
        tick();
        cyc(1);
        drained("run_drop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
